// File: rtl/change_dispenser_pkg.sv
// change_dispenser_pkg: shared coin constants and FSM encoding for the change dispenser
package change_dispenser_pkg;
  localparam int kNumCoins  = 3;
  localparam int kTotalBits = 16;
  localparam logic [kTotalBits-1:0] COIN_VAL0 = 16'd100;
  localparam logic [kTotalBits-1:0] COIN_VAL1 = 16'd500;
  localparam logic [kTotalBits-1:0] COIN_VAL2 = 16'd1000;
  localparam logic [kNumCoins-1:0][kTotalBits-1:0] kCoinVals = {COIN_VAL2, COIN_VAL1, COIN_VAL0};
  typedef enum logic [1:0] {IDLE, DISPENSE, DONE} state_t;
endpackage

// File: rtl/change_dispenser_coin_selector.sv
// change_dispenser_coin_selector: greedy pick of the largest stocked coin not exceeding rem
module change_dispenser_coin_selector
  import change_dispenser_pkg::*;
(
  input  logic [kTotalBits-1:0] rem,
  input  logic [kNumCoins-1:0]  avail,
  output logic [kNumCoins-1:0]  pick,
  output logic                  valid,
  output logic [kTotalBits-1:0] val
);
  // Scan upward so a larger eligible denomination overrides any smaller one
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    val   = '0;
    for (int k = 0; k < kNumCoins; k++)
      if (avail[k] && kCoinVals[k] <= rem) begin
        pick    = '0;
        pick[k] = 1'b1;
        valid   = 1'b1;
        val     = kCoinVals[k];
      end
  end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a latched amount one coin per cycle from finite per-coin stock
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int STOCK_W    = 8,
  parameter int INIT_STOCK = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_start,
  input  logic [kTotalBits-1:0] i_amount,
  input  logic                  i_refill,
  output logic [kNumCoins-1:0]  o_return_coin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [kTotalBits-1:0] o_remainder,
  output logic [kNumCoins-1:0]  o_stock_empty
);
  state_t                state, state_nx;
  logic [kTotalBits-1:0] rem;
  logic [STOCK_W-1:0]    stock [kNumCoins];
  logic [kNumCoins-1:0]  avail, pick;
  logic                  valid;
  logic [kTotalBits-1:0] val;

  // A denomination is usable only while its stock is nonzero
  always_comb begin
    avail = '0;
    for (int k = 0; k < kNumCoins; k++) avail[k] = stock[k] != '0;
  end

  assign o_stock_empty = ~avail;
  assign o_busy        = state != IDLE;

  change_dispenser_coin_selector u_sel (
    .rem   (rem),
    .avail (avail),
    .pick  (pick),
    .valid (valid),
    .val   (val)
  );

  // Next state: leave DISPENSE once nothing more can be paid
  always_comb begin
    state_nx = (state == IDLE)     ? (i_start ? DISPENSE : IDLE) :
               (state == DISPENSE) ? (valid ? DISPENSE : DONE) : IDLE;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Datapath: latch amount, release coins, decrement stock, report leftover
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem           <= '0;
      o_return_coin <= '0;
      o_done        <= 1'b0;
      o_remainder   <= '0;
      for (int k = 0; k < kNumCoins; k++) stock[k] <= STOCK_W'(INIT_STOCK);
    end else begin
      o_return_coin <= '0;
      o_done        <= 1'b0;
      if (state == IDLE) begin
        if (i_start) rem <= i_amount;
        if (i_refill) for (int k = 0; k < kNumCoins; k++) stock[k] <= STOCK_W'(INIT_STOCK);
      end else if (state == DISPENSE) begin
        if (valid) begin
          o_return_coin <= pick;
          rem           <= rem - val;
          for (int k = 0; k < kNumCoins; k++)
            if (pick[k]) stock[k] <= stock[k] - STOCK_W'(1);
        end else begin
          o_remainder <= rem;
          o_done      <= 1'b1;
        end
      end
    end
  end
endmodule
